// File: rtl/masked_adder_pkg.sv
// Shared definitions for the two-share masked serial adder.
// Contents:
//   state_e      - adder control FSM states
//   NUM_SHARES   - Boolean shares per masked variable
//   RND_PER_BIT  - fresh random bits consumed per processed bit
//   idx_width()  - width of the bit-index counter (clog2, minimum 1)
package masked_adder_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompute = 2'd1,
        StCombine = 2'd2,
        StDone    = 2'd3
    } state_e;

    localparam int unsigned NUM_SHARES  = 2;
    localparam int unsigned RND_PER_BIT = 2;

    function automatic int unsigned idx_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/dom_and_reg.sv
// Registered two-share domain-oriented AND gadget: z = x & y.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   en             - load the four partial-product registers
//   x0, x1, y0, y1 - input shares
//   r              - fresh random bit that masks both cross terms
//   z0, z1         - output shares, combinational from the registered terms
module dom_and_reg (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic x0,
    input  logic x1,
    input  logic y0,
    input  logic y1,
    input  logic r,
    output logic z0,
    output logic z1
);

    logic r_x0y0;
    logic r_x1y1;
    logic r_x0y1;
    logic r_x1y0;

    // Cross terms are masked with r and registered before they are folded into
    // a share domain, so no glitch can expose x0&y1 next to x0&y0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0y0 <= 1'b0;
            r_x1y1 <= 1'b0;
            r_x0y1 <= 1'b0;
            r_x1y0 <= 1'b0;
        end else if (en) begin
            r_x0y0 <= x0 & y0;
            r_x1y1 <= x1 & y1;
            r_x0y1 <= (x0 & y1) ^ r;
            r_x1y0 <= (x1 & y0) ^ r;
        end
    end

    assign z0 = r_x0y0 ^ r_x0y1;
    assign z1 = r_x1y1 ^ r_x1y0;

endmodule

// File: rtl/masked_serial_adder.sv
// Two-share Boolean-masked WIDTH-bit ripple adder, one bit per two cycles.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   in_valid / in_ready    - operand handshake
//   a0, a1, b0, b1         - shares of operands A and B
//   cin0, cin1             - shares of the carry-in
//   rnd, rnd_req           - fresh randomness, sampled at COMPUTE edges only
//   out_valid / out_ready  - result handshake
//   sum0, sum1             - shares of (A + B + cin) mod 2^WIDTH
//   cout0, cout1           - shares of the carry-out
module masked_serial_adder
    import masked_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a0,
    input  logic [WIDTH-1:0]       a1,
    input  logic [WIDTH-1:0]       b0,
    input  logic [WIDTH-1:0]       b1,
    input  logic                   cin0,
    input  logic                   cin1,
    input  logic [RND_PER_BIT-1:0] rnd,
    output logic                   rnd_req,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       sum0,
    output logic [WIDTH-1:0]       sum1,
    output logic                   cout0,
    output logic                   cout1
);

    localparam int unsigned    IW       = idx_width(WIDTH);
    localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a0, r_a1, r_b0, r_b1;
    logic [WIDTH-1:0] r_sum0, r_sum1;
    logic             r_c0, r_c1;
    logic             r_cout0, r_cout1;
    logic [IW-1:0]    r_idx;

    logic w_p0, w_p1;
    logic w_s0, w_s1;
    logic w_g0, w_g1;
    logic w_t0, w_t1;
    logic w_compute;
    logic w_last;

    // Every expression below stays inside one share domain.
    assign w_p0      = r_a0[0] ^ r_b0[0];
    assign w_p1      = r_a1[0] ^ r_b1[0];
    assign w_s0      = w_p0 ^ r_c0;
    assign w_s1      = w_p1 ^ r_c1;
    assign w_compute = (r_state == StCompute);
    assign w_last    = (r_idx == LAST_IDX);

    // Generate term g = a & b.
    dom_and_reg u_gen (
        .clk (clk),
        .rst (rst),
        .en  (w_compute),
        .x0  (r_a0[0]),
        .x1  (r_a1[0]),
        .y0  (r_b0[0]),
        .y1  (r_b1[0]),
        .r   (rnd[0]),
        .z0  (w_g0),
        .z1  (w_g1)
    );

    // Propagate term t = c & p; g and t are never both 1, so XOR acts as OR.
    dom_and_reg u_prop (
        .clk (clk),
        .rst (rst),
        .en  (w_compute),
        .x0  (r_c0),
        .x1  (r_c1),
        .y0  (w_p0),
        .y1  (w_p1),
        .r   (rnd[1]),
        .z0  (w_t0),
        .z1  (w_t1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (in_valid) w_state_next = StCompute;
            StCompute: w_state_next = StCombine;
            StCombine: w_state_next = w_last ? StDone : StCompute;
            StDone:    if (out_ready) w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        rnd_req   = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            StIdle:    in_ready  = ~rst;
            StCompute: rnd_req   = 1'b1;
            StDone:    out_valid = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a0    <= '0;
            r_a1    <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_sum0  <= '0;
            r_sum1  <= '0;
            r_c0    <= 1'b0;
            r_c1    <= 1'b0;
            r_cout0 <= 1'b0;
            r_cout1 <= 1'b0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a0  <= a0;
                        r_a1  <= a1;
                        r_b0  <= b0;
                        r_b1  <= b1;
                        r_c0  <= cin0;
                        r_c1  <= cin1;
                        r_idx <= '0;
                    end
                end
                StCompute: begin
                    // Sum bits enter at the MSB; after WIDTH steps bit 0 sits at the LSB.
                    r_sum0 <= (r_sum0 >> 1) | (WIDTH'(w_s0) << (WIDTH - 1));
                    r_sum1 <= (r_sum1 >> 1) | (WIDTH'(w_s1) << (WIDTH - 1));
                end
                StCombine: begin
                    r_c0 <= w_g0 ^ w_t0;
                    r_c1 <= w_g1 ^ w_t1;
                    if (w_last) begin
                        r_cout0 <= w_g0 ^ w_t0;
                        r_cout1 <= w_g1 ^ w_t1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        r_a0  <= r_a0 >> 1;
                        r_a1  <= r_a1 >> 1;
                        r_b0  <= r_b0 >> 1;
                        r_b1  <= r_b1 >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum0  = r_sum0;
    assign sum1  = r_sum1;
    assign cout0 = r_cout0;
    assign cout1 = r_cout1;

endmodule

// File: tb/tb_masked_serial_adder.sv
// Self-checking bench for masked_serial_adder: driver pushes the reference result
// (plain A+B+cin) into a scoreboard; a negedge monitor pops and compares on each
// output handshake and also checks latency, rnd_req count and DONE stability.
module tb_masked_serial_adder;

    parameter int unsigned WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a0, a1, b0, b1;
    logic             cin0, cin1;
    logic [1:0]       rnd;
    logic             rnd_req;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum0, sum1;
    logic             cout0, cout1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // Background stimulus knobs
    int   rnd_mode    = 0;   // 0: 00, 1: 01, 3: 11, 2: random each cycle
    logic [1:0] rnd_rand  = 2'b00;
    bit   rand_ready  = 1'b0;
    logic ready_level = 1'b1;
    logic rr_bit      = 1'b1;

    assign rnd       = (rnd_mode == 2) ? rnd_rand : 2'(rnd_mode);
    assign out_ready = rand_ready ? rr_bit : ready_level;

    always #5 clk = ~clk;

    masked_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
        .cin0      (cin0),
        .cin1      (cin1),
        .rnd       (rnd),
        .rnd_req   (rnd_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum0      (sum0),
        .sum1      (sum1),
        .cout0     (cout0),
        .cout1     (cout1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        rnd_rand = 2'($urandom);
        rr_bit   = ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitor ----------------
    int               cyc = 0;
    int               accept_cyc = 0;
    int               rnd_cnt = 0;
    bit               seen = 1'b0;
    bit               idle_chk = 1'b0;
    logic [WIDTH-1:0] hold_s0, hold_s1;
    logic             hold_c0, hold_c1;
    logic [WIDTH-1:0] last_s0 = '0;
    logic             last_c0 = 1'b0;
    exp_t             e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            seen     = 1'b0;
            idle_chk = 1'b0;
            rnd_cnt  = 0;
        end else begin
            if (idle_chk) begin
                chk("in_ready_after_done", in_ready, 1);
                idle_chk = 1'b0;
            end
            if (in_valid && in_ready) accept_cyc = cyc;
            if (rnd_req) rnd_cnt++;
            if (out_valid) begin
                chk("in_ready_low_in_done", in_ready, 0);
                if (!seen) begin
                    seen = 1'b1;
                    // Acceptance seen at the negedge before E0; out_valid first
                    // visible at the negedge after edge E0+2*WIDTH.
                    chk("latency", cyc - accept_cyc, 2 * WIDTH + 1);
                    chk("rnd_req_cycles", rnd_cnt, WIDTH);
                    rnd_cnt = 0;
                    hold_s0 = sum0;
                    hold_s1 = sum1;
                    hold_c0 = cout0;
                    hold_c1 = cout1;
                end else begin
                    chk("hold_sum_shares", {sum1, sum0}, {hold_s1, hold_s0});
                    chk("hold_cout_shares", {cout1, cout0}, {hold_c1, hold_c0});
                end
                if (out_ready) begin
                    chk("scoreboard_nonempty", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("sum", sum0 ^ sum1, e.sum);
                        chk("cout", cout0 ^ cout1, e.cout);
                    end
                    last_s0  = sum0;
                    last_c0  = cout0;
                    seen     = 1'b0;
                    idle_chk = 1'b1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] x1,
                         input logic [WIDTH-1:0] y0, input logic [WIDTH-1:0] y1,
                         input logic c0, input logic c1);
        logic [WIDTH:0] full;
        bit ok;
        @(posedge clk);
        #1;
        a0 = x0; a1 = x1; b0 = y0; b1 = y1; cin0 = c0; cin1 = c1;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accepted", ok, 1);
        if (ok) begin
            full = {1'b0, x0 ^ x1} + {1'b0, y0 ^ y1} + (WIDTH + 1)'(c0 ^ c1);
            sb.push_back('{sum: full[WIDTH-1:0], cout: full[WIDTH]});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_rand();
        logic [WIDTH-1:0] va, vb, ma, mb;
        logic vc, mc;
        va = WIDTH'($urandom); vb = WIDTH'($urandom);
        ma = WIDTH'($urandom); mb = WIDTH'($urandom);
        vc = 1'($urandom);     mc = 1'($urandom);
        issue(ma, va ^ ma, mb, vb ^ mb, mc, vc ^ mc);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_rnd_req"}, rnd_req, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_sum"}, {sum1, sum0}, 0);
        chk({tag, "_cout"}, {cout1, cout0}, 0);
    endtask

    logic [WIDTH-1:0] base_s0;
    logic             base_c0;
    bit               got_valid;

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0; cin0 = 1'b0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);

        // Basic add under different randomness; unmasked result must not move.
        rnd_mode = 0;
        issue(WIDTH'(8'h3C), WIDTH'(8'h66), WIDTH'(8'h11), WIDTH'(8'h36), 1'b0, 1'b0);
        drain();
        base_s0 = last_s0;
        base_c0 = last_c0;
        rnd_mode = 3;
        issue(WIDTH'(8'h3C), WIDTH'(8'h66), WIDTH'(8'h11), WIDTH'(8'h36), 1'b0, 1'b0);
        drain();
        // r0^r1 = 1 at every step flips the carry share, so share 0 must change.
        rnd_mode = 1;
        issue(WIDTH'(8'h3C), WIDTH'(8'h66), WIDTH'(8'h11), WIDTH'(8'h36), 1'b0, 1'b0);
        drain();
        chk("shares_differ", ({last_s0, last_c0} != {base_s0, base_c0}), 1);
        rnd_mode = 2;
        issue(WIDTH'(8'h3C), WIDTH'(8'h66), WIDTH'(8'h11), WIDTH'(8'h36), 1'b0, 1'b0);
        drain();

        // Overflow and carry-in.
        issue(WIDTH'(8'h5A), WIDTH'(8'hA5), WIDTH'(8'hC3), WIDTH'(8'hC2), 1'b0, 1'b0);
        issue(WIDTH'(8'h5A), WIDTH'(8'hA5), WIDTH'(8'h77), WIDTH'(8'h77), 1'b1, 1'b0);
        drain();

        // Back-pressure: out_ready low for 5 cycles in DONE.
        ready_level = 1'b0;
        issue_rand();
        got_valid = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got_valid = 1'b1;
                break;
            end
        end
        chk("stall_out_valid", got_valid, 1);
        repeat (5) @(negedge clk);
        chk("stall_still_valid", out_valid, 1);
        @(posedge clk);
        #1 ready_level = 1'b1;
        drain();

        // Reset in the middle of an operation.
        issue_rand();
        repeat ((WIDTH >= 4) ? 6 : 0) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk_zero("mid_reset");
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        issue(WIDTH'(8'h09), WIDTH'(8'h08), WIDTH'(8'h03), WIDTH'(8'h02), 1'b0, 1'b0);
        drain();

        // Randomised regression with random rnd and out_ready stalls.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) issue_rand();
        drain();
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
